// File: rtl/shim_ad5676_pkg.sv
// Shared constants, AD5676 command codes and SPI transmitter states for the DAC shim.
package shim_ad5676_pkg;

  localparam int SPI_CMD_BITS  = 24;
  localparam int N_CS_HIGH_MIN = 3;

  localparam logic [3:0] WRITE_INPUT  = 4'h1;
  localparam logic [3:0] UPDATE       = 4'h2;
  localparam logic [3:0] WRITE_UPDATE = 4'h3;
  localparam logic [3:0] POWER        = 4'h4;
  localparam logic [3:0] RESET        = 4'h6;

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT_LO, SHIFT_HI, HOLD} state_e;

  // The calculator may request fewer periods than the DAC tolerates; never go below the floor.
  function automatic logic [4:0] clamp_n_cs_high(input logic [4:0] t);
    return (t < 5'(N_CS_HIGH_MIN)) ? 5'(N_CS_HIGH_MIN) : t;
  endfunction

endpackage

// File: rtl/shim_ad5676_dac_spi_tx.sv
// AD5676 SPI transmitter: shifts 24-bit command words out MSB first and enforces the
// calculator-supplied n_cs high time between frames.
module shim_ad5676_dac_spi_tx
  import shim_ad5676_pkg::*;
#(
  parameter int HALF_PERIOD = 1,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4:0]              n_cs_high_time,
  input  logic                    timing_valid,
  input  logic [SPI_CMD_BITS-1:0] cmd_data,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    timing_err_clr,
  output logic                    timing_err,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    n_cs,
  output logic                    sclk,
  output logic                    sdi
);

  localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [4:0]       BIT_LAST = 5'(SPI_CMD_BITS - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        hp_cnt_q, hp_cnt_d;
  logic [CNT_W-1:0]        hold_cnt_q, hold_cnt_d;
  logic [4:0]              bit_cnt_q, bit_cnt_d;
  logic [4:0]              n_hold_q, n_hold_d;
  logic [SPI_CMD_BITS-1:0] shreg_q, shreg_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    timing_err_q, timing_err_d;
  logic                    frame_done_q, frame_done_d;
  logic                    busy_q, busy_d;
  logic                    n_cs_q, n_cs_d;
  logic                    sclk_q, sclk_d;
  logic                    sdi_q, sdi_d;
  logic                    hp_last;
  logic                    on_wire;

  always_comb begin
    // NOTE: every _d starts from its _q (or a pulse default) so no path leaves it unassigned and infers a latch.
    state_d      = state_q;
    hp_cnt_d     = hp_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    n_hold_d     = n_hold_q;
    shreg_d      = shreg_q;
    frame_done_d = 1'b0;
    hp_last      = (hp_cnt_q == HP_LAST);

    timing_err_d = timing_err_q & ~timing_err_clr;
    if (state_q == IDLE && cmd_valid && !timing_valid) timing_err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          shreg_d   = cmd_data;
          n_hold_d  = clamp_n_cs_high(n_cs_high_time);
          hp_cnt_d  = '0;
          bit_cnt_d = '0;
          state_d   = LEAD;
        end
      end
      LEAD: begin
        hp_cnt_d = hp_cnt_q + CNT_W'(1);
        if (hp_last) begin
          hp_cnt_d = '0;
          state_d  = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        hp_cnt_d = hp_cnt_q + CNT_W'(1);
        if (hp_last) begin
          hp_cnt_d = '0;
          state_d  = SHIFT_HI;
          // The final bit stays on sdi through the last high phase.
          if (bit_cnt_q != BIT_LAST) shreg_d = {shreg_q[SPI_CMD_BITS-2:0], 1'b0};
        end
      end
      SHIFT_HI: begin
        hp_cnt_d = hp_cnt_q + CNT_W'(1);
        if (hp_last) begin
          hp_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d      = HOLD;
            frame_done_d = 1'b1;
            // Counts down to zero; the IDLE accept cycle completes the (N+1) SCLK periods.
            hold_cnt_d   = CNT_W'((int'(n_hold_q) + 1) * 2 * HALF_PERIOD - 2);
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            state_d   = SHIFT_LO;
          end
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) state_d = IDLE;
        else                  hold_cnt_d = hold_cnt_q - CNT_W'(1);
      end
    endcase

    on_wire     = state_d inside {LEAD, SHIFT_LO, SHIFT_HI};
    n_cs_d      = ~on_wire;
    sclk_d      = (state_d != SHIFT_LO);
    sdi_d       = on_wire & shreg_d[SPI_CMD_BITS-1];
    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE) & timing_valid;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hp_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      n_hold_q     <= '0;
      shreg_q      <= '0;
      cmd_ready_q  <= 1'b0;
      timing_err_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      n_cs_q       <= 1'b1;
      sclk_q       <= 1'b1;
      sdi_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hp_cnt_q     <= hp_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      n_hold_q     <= n_hold_d;
      shreg_q      <= shreg_d;
      cmd_ready_q  <= cmd_ready_d;
      timing_err_q <= timing_err_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      n_cs_q       <= n_cs_d;
      sclk_q       <= sclk_d;
      sdi_q        <= sdi_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign timing_err = timing_err_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign n_cs       = n_cs_q;
  assign sclk       = sclk_q;
  assign sdi        = sdi_q;

endmodule

// File: tb/tb_shim_ad5676_dac_spi_tx.sv
// Scoreboard bench: stimulus queues the expected frame per accepted word; per-instance
// monitors decode n_cs/sclk/sdi and compare. Instance 0 uses HALF_PERIOD=1, instance 1 uses 2.
module tb_shim_ad5676_dac_spi_tx;
  import shim_ad5676_pkg::*;

  typedef struct {
    int          g;
    logic [23:0] word;
    int          n;
    bit          b2b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a [2];
  logic [4:0]  t_a     [2];
  logic        tv_a    [2];
  logic [23:0] data_a  [2];
  logic        cv_a    [2];
  logic        clr_a   [2];
  logic        ready_a [2];
  logic        err_a   [2];
  logic        done_a  [2];
  logic        busy_a  [2];
  logic        ncs_a   [2];
  logic        sclk_a  [2];
  logic        sdi_a   [2];

  exp_t        exp_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [3:0]  codes [5];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int H = g + 1;

    shim_ad5676_dac_spi_tx #(.HALF_PERIOD(H), .CNT_W(8)) dut (
      .clk            (clk),
      .reset          (reset_a[g]),
      .n_cs_high_time (t_a[g]),
      .timing_valid   (tv_a[g]),
      .cmd_data       (data_a[g]),
      .cmd_valid      (cv_a[g]),
      .cmd_ready      (ready_a[g]),
      .timing_err_clr (clr_a[g]),
      .timing_err     (err_a[g]),
      .frame_done     (done_a[g]),
      .busy           (busy_a[g]),
      .n_cs           (ncs_a[g]),
      .sclk           (sclk_a[g]),
      .sdi            (sdi_a[g])
    );

    int          cyc        = 0;
    int          low_len    = 0;
    int          falls      = 0;
    int          rise_cyc   = 0;
    logic [23:0] cap        = '0;
    logic        prev_ncs   = 1'b1;
    logic        prev_sclk  = 1'b1;
    bit          prev_valid = 1'b0;
    bit          rise;
    exp_t        prev;
    exp_t        e;

    // Monitor: samples pins mid-cycle, decodes a frame at each n_cs rise.
    always @(negedge clk) begin
      cyc++;
      if (reset_a[g]) begin
        prev_ncs   = 1'b1;
        prev_sclk  = 1'b1;
        prev_valid = 1'b0;
      end else begin
        if (prev_ncs && !ncs_a[g]) begin
          if (prev_valid && prev.b2b) check($sformatf("gap_h%0d", H), cyc - rise_cyc, (prev.n + 1) * 2 * H);
          prev_valid = 1'b0;
          low_len    = 0;
          falls      = 0;
          cap        = '0;
        end
        if (!ncs_a[g]) begin
          low_len++;
          if (prev_sclk && !sclk_a[g]) begin
            cap = {cap[22:0], sdi_a[g]};
            falls++;
          end
        end else begin
          check($sformatf("sclk_idle_h%0d", H), int'(sclk_a[g]), 1);
        end
        rise = !prev_ncs && ncs_a[g];
        if (rise || done_a[g]) check($sformatf("frame_done_h%0d", H), int'(done_a[g]), int'(rise));
        if (rise) begin
          rise_cyc = cyc;
          check($sformatf("frame_expected_h%0d", H), int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_inst", g, e.g);
            check($sformatf("word_h%0d", H), int'(cap), int'(e.word));
            check($sformatf("ncs_low_h%0d", H), low_len, 49 * H);
            check($sformatf("falls_h%0d", H), falls, 24);
            prev       = e;
            prev_valid = 1'b1;
          end
        end
        prev_ncs  = ncs_a[g];
        prev_sclk = sclk_a[g];
      end
    end
  end

  // Presents a word (held valid) and records the frame the DAC must see once accepted.
  task automatic issue(input int g, input logic [23:0] w, input logic [4:0] t,
                       input logic [4:0] t_mid, input bit last, input bit push);
    int   waited = 0;
    bit   ok;
    exp_t x;
    data_a[g] = w;
    t_a[g]    = t;
    cv_a[g]   = 1'b1;
    @(negedge clk);
    while (!ready_a[g] && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    ok = ready_a[g];
    check("accept_timeout", int'(ok), 1);
    if (ok) begin
      @(posedge clk);
      #1;
      if (push) begin
        x.g    = g;
        x.word = w;
        x.n    = (int'(t) < N_CS_HIGH_MIN) ? N_CS_HIGH_MIN : int'(t);
        x.b2b  = !last;
        exp_q.push_back(x);
      end
      t_a[g] = t_mid;
    end
    if (last || !ok) cv_a[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    @(negedge clk);
    while (busy_a[g] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(busy_a[g]), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    automatic int          rg;
    automatic int          len;
    automatic logic [23:0] w;
    codes = '{WRITE_INPUT, UPDATE, WRITE_UPDATE, POWER, RESET};
    for (int g = 0; g < 2; g++) begin
      reset_a[g] = 1'b1;
      t_a[g]     = 5'd3;
      tv_a[g]    = 1'b1;
      data_a[g]  = '0;
      cv_a[g]    = 1'b0;
      clr_a[g]   = 1'b0;
    end
    #1;
    for (int g = 0; g < 2; g++) begin
      check("rst_n_cs", int'(ncs_a[g]), 1);
      check("rst_sclk", int'(sclk_a[g]), 1);
      check("rst_sdi", int'(sdi_a[g]), 0);
      check("rst_ready", int'(ready_a[g]), 0);
      check("rst_busy", int'(busy_a[g]), 0);
      check("rst_done", int'(done_a[g]), 0);
      check("rst_err", int'(err_a[g]), 0);
    end
    @(posedge clk);
    #2;
    reset_a[0] = 1'b0;
    reset_a[1] = 1'b0;

    // Single frame.
    issue(0, 24'h31ABCD, 5'd3, 5'd3, 1, 1);
    wait_idle(0);
    // Back-to-back, N=3 then N=31.
    issue(0, 24'h301234, 5'd3, 5'd3, 0, 1);
    issue(0, 24'h37FFFF, 5'd3, 5'd3, 1, 1);
    wait_idle(0);
    issue(0, 24'h301234, 5'd31, 5'd31, 0, 1);
    issue(0, 24'h37FFFF, 5'd31, 5'd31, 1, 1);
    wait_idle(0);
    // Slow SCLK instance.
    issue(1, 24'h301234, 5'd3, 5'd3, 0, 1);
    issue(1, 24'h37FFFF, 5'd3, 5'd3, 1, 1);
    wait_idle(1);
    // Clamp and mid-frame timing change.
    issue(0, 24'h2A5A5A, 5'd1, 5'd1, 0, 1);
    issue(0, 24'h15A5A5, 5'd1, 5'd1, 1, 1);
    wait_idle(0);
    issue(0, 24'h3F0F0F, 5'd3, 5'd31, 0, 1);
    issue(0, 24'h40F0F0, 5'd31, 5'd31, 1, 1);
    wait_idle(0);

    // No timing available.
    tv_a[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cv_a[0] = 1'b1;
    @(negedge clk);
    check("nt_ready", int'(ready_a[0]), 0);
    check("nt_err_before", int'(err_a[0]), 0);
    @(posedge clk);
    #1;
    cv_a[0]  = 1'b0;
    clr_a[0] = 1'b1;
    @(negedge clk);
    check("nt_err_set", int'(err_a[0]), 1);
    check("nt_n_cs", int'(ncs_a[0]), 1);
    check("nt_sclk", int'(sclk_a[0]), 1);
    check("nt_sdi", int'(sdi_a[0]), 0);
    @(posedge clk);
    #1;
    cv_a[0] = 1'b1;
    @(negedge clk);
    check("nt_err_clr", int'(err_a[0]), 0);
    @(posedge clk);
    #1;
    cv_a[0]  = 1'b0;
    clr_a[0] = 1'b0;
    @(negedge clk);
    check("nt_set_wins", int'(err_a[0]), 1);
    check("nt_busy", int'(busy_a[0]), 0);
    clr_a[0] = 1'b1;
    @(posedge clk);
    #1;
    clr_a[0] = 1'b0;
    tv_a[0]  = 1'b1;
    @(negedge clk);
    check("nt_err_final", int'(err_a[0]), 0);
    @(posedge clk);
    #1;

    // Asynchronous reset around bit 10 of an abandoned frame.
    issue(0, 24'h3A5A5A, 5'd3, 5'd3, 1, 0);
    repeat (21) @(posedge clk);
    #2;
    check("mid_pre_n_cs", int'(ncs_a[0]), 0);
    check("mid_pre_sclk", int'(sclk_a[0]), 0);
    reset_a[0] = 1'b1;
    #1;
    check("mid_n_cs", int'(ncs_a[0]), 1);
    check("mid_sclk", int'(sclk_a[0]), 1);
    check("mid_sdi", int'(sdi_a[0]), 0);
    check("mid_busy", int'(busy_a[0]), 0);
    repeat (2) @(posedge clk);
    #2;
    reset_a[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_ready_after", int'(ready_a[0]), 1);
    @(posedge clk);
    #1;

    // Randomised bursts on either instance.
    for (int b = 0; b < 14; b++) begin
      rg  = $urandom_range(0, 1);
      len = $urandom_range(1, 3);
      for (int k = 0; k < len; k++) begin
        w = {codes[$urandom_range(0, 4)], 4'($urandom_range(0, 15)), 16'($urandom)};
        issue(rg, w, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), k == len - 1, 1);
      end
      wait_idle(rg);
    end

    repeat (4) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
